// File: rtl/coffee_pkg.sv
// Shared types and lookup functions for the coffee vending controller.
package coffee_pkg;

  typedef enum logic [2:0] {
    IDLE, WAIT_PAY, COFFEE, MILK, CHOC, FOAM, DONE, REFUND
  } state_t;

  localparam logic [3:0] DRINK_EXPRESSO  = 4'b0001;
  localparam logic [3:0] DRINK_C_LECHE   = 4'b0010;
  localparam logic [3:0] DRINK_CAPUCCINO = 4'b0100;
  localparam logic [3:0] DRINK_MOCACCINO = 4'b1000;

  localparam logic [3:0] STEP_NONE   = 4'b0000;
  localparam logic [3:0] STEP_COFFEE = 4'b0001;
  localparam logic [3:0] STEP_MILK   = 4'b0010;
  localparam logic [3:0] STEP_CHOC   = 4'b0100;
  localparam logic [3:0] STEP_FOAM   = 4'b1000;

  function automatic logic [3:0] cost_of(input logic [3:0] drink);
    case (drink)
      DRINK_EXPRESSO:  return 4'd1;
      DRINK_C_LECHE:   return 4'd2;
      DRINK_CAPUCCINO: return 4'd3;
      DRINK_MOCACCINO: return 4'd4;
      default:         return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   return 4'd1;
      2'b10:   return 4'd2;
      2'b11:   return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  // STEP_NONE means the recipe is finished.
  function automatic logic [3:0] recipe_next(input logic [3:0] drink, input logic [3:0] step);
    case (step)
      STEP_COFFEE: begin
        if (drink == DRINK_EXPRESSO)  return STEP_NONE;
        if (drink == DRINK_MOCACCINO) return STEP_CHOC;
        return STEP_MILK;
      end
      STEP_CHOC: return STEP_MILK;
      STEP_MILK: begin
        if (drink == DRINK_CAPUCCINO || drink == DRINK_MOCACCINO) return STEP_FOAM;
        return STEP_NONE;
      end
      default: return STEP_NONE;
    endcase
  endfunction

  function automatic state_t state_of(input logic [3:0] step);
    case (step)
      STEP_COFFEE: return COFFEE;
      STEP_MILK:   return MILK;
      STEP_CHOC:   return CHOC;
      STEP_FOAM:   return FOAM;
      default:     return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/coffee_order_fsm_sec_down_timer.sv
// Seconds down-counter shared by pay timeout, serve steps and the DONE hold.
module sec_down_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       tick,
  output logic [3:0] count,
  output logic       expired
);

  always_ff @(posedge clk) begin
    if (!rst)                     count <= 4'd0;
    else if (load)                count <= value;
    else if (tick && count != 0)  count <= count - 4'd1;
  end

  // The tick that would take the count from 1 to 0 ends the interval.
  assign expired = tick && (count == 4'd1);

endmodule

// File: rtl/coffee_order_fsm.sv
// Coffee vending controller: drink latch, payment, refund and timed serve sequence.
module coffee_order_fsm
  import coffee_pkg::*;
#(
  parameter logic [3:0] T_COFFEE    = 4'd3,
  parameter logic [3:0] T_MILK      = 4'd2,
  parameter logic [3:0] T_CHOC      = 4'd2,
  parameter logic [3:0] T_FOAM      = 4'd1,
  parameter logic [3:0] PAY_TIMEOUT = 4'd9,
  parameter logic [3:0] DONE_HOLD   = 4'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic [3:0] btn_n,
  input  logic       cancel,
  input  logic [1:0] coin_code,
  input  logic       coin_valid,
  output logic [3:0] drink_sel,
  output logic [3:0] amount,
  output logic [3:0] step_code,
  output logic [3:0] sec_left,
  output logic [3:0] change,
  output logic [3:0] refund,
  output logic       refund_vld,
  output logic       coin_reject,
  output logic       done
);

  state_t     state;
  logic       entry_cyc;
  logic       tick_eff, expired, tmr_load;
  logic [3:0] tmr_val, new_amt, nxt_step;
  logic [4:0] sum;
  logic       btn_one, paid, abort;

  function automatic logic [3:0] step_time(input logic [3:0] s);
    case (s)
      STEP_COFFEE: return T_COFFEE;
      STEP_MILK:   return T_MILK;
      STEP_CHOC:   return T_CHOC;
      STEP_FOAM:   return T_FOAM;
      default:     return DONE_HOLD;
    endcase
  endfunction

  // A tick landing in the first cycle of a timed interval is dropped.
  assign tick_eff = tick_1s && !entry_cyc;

  sec_down_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_val),
    .tick    (tick_eff),
    .count   (sec_left),
    .expired (expired)
  );

  always_comb begin
    sum      = {1'b0, amount} + {1'b0, (coin_valid ? coin_value(coin_code) : 4'd0)};
    new_amt  = sum[4] ? 4'hF : sum[3:0];
    paid     = new_amt >= cost_of(drink_sel);
    abort    = cancel || expired;
    btn_one  = $onehot(~btn_n);
    nxt_step = recipe_next(drink_sel, step_code);
    tmr_load = 1'b0;
    tmr_val  = 4'd0;
    case (state)
      IDLE: if (btn_one) begin
        tmr_load = 1'b1;
        tmr_val  = PAY_TIMEOUT;
      end
      WAIT_PAY: begin
        if (abort) begin
          tmr_load = 1'b1;
          tmr_val  = 4'd0;
        end else if (paid) begin
          tmr_load = 1'b1;
          tmr_val  = T_COFFEE;
        end else if (coin_valid) begin
          tmr_load = 1'b1;
          tmr_val  = PAY_TIMEOUT;
        end
      end
      COFFEE, MILK, CHOC, FOAM: if (expired) begin
        tmr_load = 1'b1;
        tmr_val  = step_time(nxt_step);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      entry_cyc   <= 1'b0;
      drink_sel   <= 4'd0;
      amount      <= 4'd0;
      step_code   <= STEP_NONE;
      change      <= 4'd0;
      refund      <= 4'd0;
      refund_vld  <= 1'b0;
      coin_reject <= 1'b0;
      done        <= 1'b0;
    end else begin
      entry_cyc   <= 1'b0;
      refund      <= 4'd0;
      refund_vld  <= 1'b0;
      coin_reject <= coin_valid && (state != WAIT_PAY);
      case (state)
        IDLE: if (btn_one) begin
          drink_sel <= ~btn_n;
          entry_cyc <= 1'b1;
          state     <= WAIT_PAY;
        end
        WAIT_PAY: begin
          amount <= new_amt;
          // Cancel or timeout beats a coin that would complete payment.
          if (abort) begin
            refund     <= new_amt;
            refund_vld <= 1'b1;
            amount     <= 4'd0;
            state      <= REFUND;
          end else if (paid) begin
            change    <= new_amt - cost_of(drink_sel);
            step_code <= STEP_COFFEE;
            entry_cyc <= 1'b1;
            state     <= COFFEE;
          end
        end
        COFFEE, MILK, CHOC, FOAM: if (expired) begin
          entry_cyc <= 1'b1;
          step_code <= nxt_step;
          if (nxt_step == STEP_NONE) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= state_of(nxt_step);
          end
        end
        DONE: if (expired) begin
          amount    <= 4'd0;
          change    <= 4'd0;
          drink_sel <= 4'd0;
          done      <= 1'b0;
          state     <= IDLE;
        end
        REFUND: begin
          drink_sel <= 4'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coffee_order_fsm.sv
// Directed bench for coffee_order_fsm with a per-cycle recipe/queue reference model.
module tb_coffee_order_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1s = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic       cancel = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       coin_valid = 1'b0;
  logic [3:0] drink_sel, amount, step_code, sec_left, change, refund;
  logic       refund_vld, coin_reject, done;

  int n_checks = 0;
  int n_fail   = 0;

  coffee_order_fsm dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .btn_n(btn_n), .cancel(cancel),
    .coin_code(coin_code), .coin_valid(coin_valid), .drink_sel(drink_sel),
    .amount(amount), .step_code(step_code), .sec_left(sec_left), .change(change),
    .refund(refund), .refund_vld(refund_vld), .coin_reject(coin_reject), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_PAY = 1, M_SERVE = 2, M_DONE = 3, M_REF = 4;
  int         mode = M_IDLE;
  bit         fresh = 1'b0;
  logic [3:0] q[$];
  logic [3:0] e_drink = 0, e_amount = 0, e_step = 0, e_sec = 0, e_change = 0, e_refund = 0;
  logic       e_refund_vld = 0, e_coin_reject = 0, e_done = 0;

  // Ingredient steps in serving order, one nibble each, lowest first.
  function automatic logic [15:0] recipe_of(input int idx);
    case (idx)
      0:       return 16'h0001;
      1:       return 16'h0021;
      2:       return 16'h0821;
      default: return 16'h8241;
    endcase
  endfunction

  function automatic logic [3:0] dur(input logic [3:0] s);
    case (s)
      4'b0001: return 4'd3;
      4'b0010: return 4'd2;
      4'b0100: return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0]  add, amt, cost;
    logic [4:0]  s;
    logic [15:0] r;
    bit          tick_ok;
    int          idx;
    if (!rst) begin
      mode = M_IDLE; fresh = 0; q.delete();
      e_drink = 0; e_amount = 0; e_step = 0; e_sec = 0; e_change = 0; e_refund = 0;
      e_refund_vld = 0; e_coin_reject = 0; e_done = 0;
      return;
    end
    tick_ok = tick_1s && !fresh;
    fresh = 0;
    e_refund_vld = 0;
    e_refund = 0;
    e_coin_reject = coin_valid && (mode != M_PAY);
    case (mode)
      M_IDLE: if ($countones(~btn_n) == 1) begin
        e_drink = ~btn_n; e_sec = 4'd9; fresh = 1; mode = M_PAY;
      end
      M_PAY: begin
        add = 4'd0;
        if (coin_valid) add = (coin_code == 2'd1) ? 4'd1 : (coin_code == 2'd2) ? 4'd2 :
                              (coin_code == 2'd3) ? 4'd5 : 4'd0;
        s = {1'b0, e_amount} + {1'b0, add};
        amt = (s > 5'd15) ? 4'd15 : s[3:0];
        idx = 0;
        for (int i = 0; i < 4; i++) if (e_drink[i]) idx = i;
        cost = 4'(idx + 1);
        if (cancel || (tick_ok && e_sec == 4'd1)) begin
          e_refund = amt; e_refund_vld = 1; e_amount = 0; e_sec = 0; mode = M_REF;
        end else if (amt >= cost) begin
          e_amount = amt; e_change = amt - cost;
          r = recipe_of(idx);
          q.delete();
          for (int k = 0; k < 4; k++) if (r[4*k +: 4] != 4'd0) q.push_back(r[4*k +: 4]);
          e_step = q[0]; e_sec = dur(q[0]); fresh = 1; mode = M_SERVE;
        end else begin
          e_amount = amt;
          if (coin_valid) e_sec = 4'd9;
          else if (tick_ok) e_sec = e_sec - 4'd1;
        end
      end
      M_SERVE: if (tick_ok) begin
        if (e_sec == 4'd1) begin
          void'(q.pop_front());
          fresh = 1;
          if (q.size() == 0) begin
            e_step = 0; e_done = 1; e_sec = 4'd3; mode = M_DONE;
          end else begin
            e_step = q[0]; e_sec = dur(q[0]);
          end
        end else e_sec = e_sec - 4'd1;
      end
      M_DONE: if (tick_ok) begin
        if (e_sec == 4'd1) begin
          e_amount = 0; e_change = 0; e_drink = 0; e_done = 0; e_sec = 0; mode = M_IDLE;
        end else e_sec = e_sec - 4'd1;
      end
      default: begin
        e_drink = 0; mode = M_IDLE;
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("m_drink_sel",   drink_sel,            e_drink);
      chk("m_amount",      amount,               e_amount);
      chk("m_step_code",   step_code,            e_step);
      chk("m_sec_left",    sec_left,             e_sec);
      chk("m_change",      change,               e_change);
      chk("m_refund",      refund,               e_refund);
      chk("m_refund_vld",  {3'b0, refund_vld},   {3'b0, e_refund_vld});
      chk("m_coin_reject", {3'b0, coin_reject},  {3'b0, e_coin_reject});
      chk("m_done",        {3'b0, done},         {3'b0, e_done});
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [3:0] b);
    @(negedge clk); btn_n = b;
    @(negedge clk); btn_n = 4'hF;
  endtask

  task automatic coin(input logic [1:0] c);
    @(negedge clk); coin_code = c; coin_valid = 1'b1;
    @(negedge clk); coin_code = 2'b00; coin_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick_1s = 1'b1;
      @(negedge clk); tick_1s = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_cycles(3);
    chk("reset_drink", drink_sel, 4'd0);
    chk("reset_sec",   sec_left,  4'd0);
    chk("reset_done",  {3'b0, done}, 4'd0);
    rst = 1'b1;
    idle_cycles(2);

    // expresso: one coin, entry-cycle tick ignored, 3 ticks, DONE hold
    press(4'b1110);
    chk("exp_drink", drink_sel, 4'b0001);
    chk("exp_pay_sec", sec_left, 4'd9);
    coin(2'b01);
    chk("exp_step", step_code, 4'b0001);
    chk("exp_sec3", sec_left, 4'd3);
    chk("exp_change", change, 4'd0);
    tick_1s = 1'b1;
    @(negedge clk); tick_1s = 1'b0;
    chk("exp_entry_tick", sec_left, 4'd3);
    ticks(3);
    chk("exp_done", {3'b0, done}, 4'd1);
    chk("exp_done_sec", sec_left, 4'd3);
    ticks(3);
    chk("exp_idle_drink", drink_sel, 4'd0);
    chk("exp_idle_amt", amount, 4'd0);

    // mocaccino: 2+1+2 = 5 against cost 4
    press(4'b0111);
    coin(2'b10); coin(2'b01); coin(2'b10);
    chk("moc_change", change, 4'd1);
    chk("moc_amount", amount, 4'd5);
    ticks(3);
    chk("moc_choc", step_code, 4'b0100);
    ticks(2);
    chk("moc_milk", step_code, 4'b0010);
    coin(2'b01);
    chk("moc_reject", {3'b0, coin_reject}, 4'd1);
    chk("moc_amt_keep", amount, 4'd5);
    ticks(2);
    chk("moc_foam", step_code, 4'b1000);
    chk("moc_foam_sec", sec_left, 4'd1);
    ticks(1);
    chk("moc_done", {3'b0, done}, 4'd1);
    ticks(3);

    // capuccino: partial payment then cancel
    press(4'b1011);
    coin(2'b10);
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    chk("cap_refund", refund, 4'd2);
    chk("cap_refund_vld", {3'b0, refund_vld}, 4'd1);
    chk("cap_amount", amount, 4'd0);
    @(negedge clk);
    chk("cap_vld_drop", {3'b0, refund_vld}, 4'd0);
    chk("cap_drink_clr", drink_sel, 4'd0);

    // c_leche: pay timeout after 9 ticks
    press(4'b1101);
    coin(2'b01);
    ticks(8);
    chk("cl_sec1", sec_left, 4'd1);
    ticks(1);
    chk("cl_refund", refund, 4'd1);
    chk("cl_refund_vld", {3'b0, refund_vld}, 4'd1);
    idle_cycles(1);

    // two buttons ignored; coin in IDLE rejected
    press(4'b1100);
    chk("two_btn", drink_sel, 4'd0);
    coin(2'b11);
    chk("idle_reject", {3'b0, coin_reject}, 4'd1);
    chk("idle_amt", amount, 4'd0);

    // coin that meets cost together with cancel: refund wins
    press(4'b1011);
    @(negedge clk); coin_code = 2'b11; coin_valid = 1'b1; cancel = 1'b1;
    @(negedge clk); coin_code = 2'b00; coin_valid = 1'b0; cancel = 1'b0;
    chk("cc_refund", refund, 4'd5);
    chk("cc_step", step_code, 4'd0);
    idle_cycles(1);

    // reset during CHOC
    press(4'b0111);
    coin(2'b11);
    ticks(3);
    chk("rst_in_choc", step_code, 4'b0100);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("rst_step", step_code, 4'd0);
    chk("rst_amount", amount, 4'd0);
    chk("rst_change", change, 4'd0);
    chk("rst_drink", drink_sel, 4'd0);
    chk("rst_vld", {3'b0, refund_vld}, 4'd0);
    idle_cycles(2);
    chk("rst_vld_after", {3'b0, refund_vld}, 4'd0);

    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
